// File: rtl/gate_trainer_self_test_if.sv
// ============================================================================
// Module  : gate_trainer_self_test_if
// Brief   : Stimulus/response bus between the self-test sequencer and the
//           gate-select trainer (a/b/sel driven out, y returned).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface gate_trainer_self_test_if;
    logic       a_out;
    logic       b_out;
    logic [2:0] sel_out;
    logic       y_in;

    modport master (
        output a_out,
        output b_out,
        output sel_out,
        input  y_in
    );

    modport slave (
        input  a_out,
        input  b_out,
        input  sel_out,
        output y_in
    );
endinterface

`default_nettype wire

// File: rtl/gate_trainer_self_test.sv
// ============================================================================
// Module  : gate_trainer_self_test
// Brief   : Built-in self-test sequencer sweeping all 28 a/b/sel vectors of the
//           gate trainer and checking y against a golden gate model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_trainer_self_test #(
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    gate_trainer_self_test_if.master       trainer,
    input  wire logic                      start,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [4:0]                     fail_count,
    output logic [4:0]                     first_fail_vec,
    output logic                           first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] c_last_vec    = 5'd27;

    state_t     r_state;
    state_t     w_state_next;

    logic       r_a;
    logic       r_b;
    logic [2:0] r_sel;
    logic [4:0] r_vec;
    logic [3:0] r_cnt;
    logic       r_done;
    logic       r_pass;
    logic [4:0] r_fail_count;
    logic [4:0] r_first_fail_vec;
    logic       r_first_fail_valid;

    logic       w_start_ok;
    logic       w_golden;
    logic       w_mismatch;
    logic       w_settled;
    logic       w_last;
    logic [4:0] w_fail_next;

    always_comb begin
        w_golden = 1'b0;
        case (r_sel)
            3'd0:    w_golden = r_a & r_b;
            3'd1:    w_golden = r_a | r_b;
            3'd2:    w_golden = ~(r_a & r_b);
            3'd3:    w_golden = ~(r_a | r_b);
            3'd4:    w_golden = r_a ^ r_b;
            3'd5:    w_golden = ~(r_a ^ r_b);
            3'd6:    w_golden = ~r_a;
            default: w_golden = 1'b0;
        endcase
    end

    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mismatch  = (r_state == CHECK) && (trainer.y_in != w_golden);
    assign w_settled   = (r_cnt == c_settle_last);
    assign w_last      = (r_vec == c_last_vec);
    assign w_fail_next = r_fail_count + {4'd0, w_mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (w_settled) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                w_state_next = w_last ? DONE : SETTLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a                <= 1'b0;
            r_b                <= 1'b0;
            r_sel              <= 3'd0;
            r_vec              <= 5'd0;
            r_cnt              <= 4'd0;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_fail_count       <= 5'd0;
            r_first_fail_vec   <= 5'd0;
            r_first_fail_valid <= 1'b0;
        end else if (w_start_ok) begin
            r_a                <= 1'b0;
            r_b                <= 1'b0;
            r_sel              <= 3'd0;
            r_vec              <= 5'd0;
            r_cnt              <= 4'd0;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_fail_count       <= 5'd0;
            r_first_fail_vec   <= 5'd0;
            r_first_fail_valid <= 1'b0;
        end else begin
            case (r_state)
                SETTLE: begin
                    r_cnt <= w_settled ? 4'd0 : (r_cnt + 4'd1);
                end
                CHECK: begin
                    r_fail_count <= w_fail_next;
                    if (w_mismatch && !r_first_fail_valid) begin
                        r_first_fail_vec   <= {r_a, r_b, r_sel};
                        r_first_fail_valid <= 1'b1;
                    end
                    if (w_last) begin
                        r_done <= 1'b1;
                        // Includes this cycle's compare result.
                        r_pass <= (w_fail_next == 5'd0);
                    end else begin
                        r_vec <= r_vec + 5'd1;
                        if (r_sel == 3'd6) begin
                            r_sel        <= 3'd0;
                            {r_a, r_b}   <= {r_a, r_b} + 2'd1;
                        end else begin
                            r_sel <= r_sel + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign trainer.a_out   = r_a;
    assign trainer.b_out   = r_b;
    assign trainer.sel_out = r_sel;

    assign busy             = (r_state == SETTLE) || (r_state == CHECK);
    assign done             = r_done;
    assign pass             = r_pass;
    assign fail_count       = r_fail_count;
    assign first_fail_vec   = r_first_fail_vec;
    assign first_fail_valid = r_first_fail_valid;

endmodule

`default_nettype wire

// File: tb/tb_gate_trainer_self_test.sv
// ============================================================================
// Module  : tb_gate_trainer_self_test
// Brief   : Self-checking bench: trainer model with injectable per-vector faults.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gate_trainer_self_test;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass, first_fail_valid;
    logic [4:0] fail_count, first_fail_vec;

    int vectors     = 0;
    int miscompares = 0;

    // Fault mask: bit k inverts the trainer's answer for sweep vector k.
    logic [27:0] mask = 28'd0;

    // Truth tables per gate, indexed by {a,b}.
    logic [3:0] truth [7] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                              4'b0110, 4'b1001, 4'b0011};

    gate_trainer_self_test_if bus ();

    gate_trainer_self_test #(.SETTLE_CYCLES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .trainer          (bus.master),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail_count       (fail_count),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    always #5 clk = ~clk;

    function automatic logic ref_y(input logic a, input logic b,
                                   input logic [2:0] sel, input logic [27:0] m);
        int         idx;
        logic [3:0] row;
        if (sel > 3'd6) return 1'b0;
        idx = int'({a, b}) * 7 + int'(sel);
        row = truth[sel];
        return row[{a, b}] ^ m[idx];
    endfunction

    assign bus.y_in = ref_y(bus.a_out, bus.b_out, bus.sel_out, mask);

    function automatic logic [4:0] vec_of(input int idx);
        logic [1:0] ab;
        logic [2:0] s;
        ab = 2'(idx / 7);
        s  = 3'(idx % 7);
        return {ab, s};
    endfunction

    function automatic logic golden_of(input int idx);
        logic [4:0] v;
        logic [3:0] row;
        v   = vec_of(idx);
        row = truth[v[2:0]];
        return row[v[4:3]];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_outs"},  32'({bus.a_out, bus.b_out, bus.sel_out, done, pass,
                                     fail_count, first_fail_vec, first_fail_valid}), 32'd0);
    endtask

    // One full sweep; start is re-pulsed at cycle inj (negative: never).
    task automatic sweep(input string tag, input int inj);
        int         seq_bad  = 0;
        int         busy_bad = 0;
        int         exp_cnt  = 0;
        logic [4:0] exp_first = 5'd0;
        logic       exp_valid = 1'b0;
        for (int k = 0; k < 28; k++) begin
            if (mask[k]) begin
                exp_cnt++;
                if (!exp_valid) begin
                    exp_first = vec_of(k);
                    exp_valid = 1'b1;
                end
            end
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 0; j < 84; j++) begin
            @(negedge clk);
            if (j == 0)
                check({tag, "_cleared"}, 32'({done, pass, fail_count, first_fail_valid}), 32'd0);
            if ({bus.a_out, bus.b_out, bus.sel_out} !== vec_of(j / 3)) seq_bad++;
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
            start = (j == inj);
        end
        start = 1'b0;
        check({tag, "_vec_seq"}, 32'(seq_bad), 32'd0);
        check({tag, "_busy84"}, 32'(busy_bad), 32'd0);
        @(negedge clk);
        check({tag, "_done"},       32'({done, busy}), 32'b10);
        check({tag, "_pass"},       32'(pass), 32'(exp_cnt == 0));
        check({tag, "_fail_count"}, 32'(fail_count), 32'(exp_cnt));
        check({tag, "_first_valid"}, 32'(first_fail_valid), 32'(exp_valid));
        check({tag, "_first_vec"},  32'(first_fail_vec), 32'(exp_first));
        check({tag, "_hold"},       32'({bus.a_out, bus.b_out, bus.sel_out}), 32'b11110);
        repeat (2) @(negedge clk);
        check({tag, "_done_held"},  32'(done), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("idle");

        mask = 28'd0;
        sweep("golden", -1);

        for (int k = 0; k < 28; k++) mask[k] = (k % 7 == 4);
        sweep("xor_inv", -1);

        for (int k = 0; k < 28; k++) mask[k] = golden_of(k);
        sweep("y_zero", -1);

        // Abort a sweep with reset at cycle 40.
        mask = 28'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("mid_rst");
        sweep("after_rst", -1);

        mask = 28'($urandom) | 28'd1 << $urandom_range(27, 0);
        sweep("rand_busy_start", 10);
        mask = 28'($urandom);
        sweep("rand_restart", -1);
        mask = {28{1'b1}};
        sweep("all_fail", -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
